// File: rtl/reg_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_pkg
// Description : Shared constants and state encoding for the register dump
//               engine.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_dump_pkg;

    localparam int c_ADDRESS_WIDTH = 5;
    localparam int c_REGISTER_SIZE = 32;

    localparam int c_STATE_W = 3;
    localparam logic [c_STATE_W-1:0] c_IDLE  = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ISSUE = 3'd1;
    localparam logic [c_STATE_W-1:0] c_WAIT  = 3'd2;
    localparam logic [c_STATE_W-1:0] c_CAPT  = 3'd3;
    localparam logic [c_STATE_W-1:0] c_SEND  = 3'd4;
    localparam logic [c_STATE_W-1:0] c_FIN   = 3'd5;

endpackage
`default_nettype wire

// File: rtl/reg_dump.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump
// Description : Walks every register-file address through a spare read port
//               and streams the captured values over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int ADDRESS_WIDTH = c_ADDRESS_WIDTH,
    parameter int REGISTER_SIZE = c_REGISTER_SIZE
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    output logic [ADDRESS_WIDTH-1:0] rd_addr,
    input  logic [REGISTER_SIZE-1:0] rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [REGISTER_SIZE-1:0] out_data,
    output logic [ADDRESS_WIDTH-1:0] out_index,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam logic [ADDRESS_WIDTH-1:0] c_MAX_ADDR = '1;
    localparam logic [ADDRESS_WIDTH-1:0] c_ONE      = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

    logic [c_STATE_W-1:0]     r_state;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [REGISTER_SIZE-1:0] r_outData;
    logic [ADDRESS_WIDTH-1:0] r_outIndex;
    logic                     r_outValid;
    logic                     r_outLast;
    logic                     r_busy;
    logic                     r_done;

    // The address counter doubles as the registered read address.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= c_IDLE;
            r_addr     <= '0;
            r_outData  <= '0;
            r_outIndex <= '0;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort && (r_state != c_IDLE)) begin
                r_state    <= c_IDLE;
                r_outValid <= 1'b0;
                r_outLast  <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (start && !abort) begin
                            r_state <= c_ISSUE;
                            r_addr  <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    c_ISSUE: r_state <= c_WAIT;
                    c_WAIT:  r_state <= c_CAPT;
                    c_CAPT: begin
                        r_outData  <= rd_data;
                        r_outIndex <= r_addr;
                        r_outLast  <= (r_addr == c_MAX_ADDR);
                        r_outValid <= 1'b1;
                        r_state    <= c_SEND;
                    end
                    c_SEND: begin
                        if (out_ready) begin
                            r_outValid <= 1'b0;
                            r_outLast  <= 1'b0;
                            if (r_addr == c_MAX_ADDR) begin
                                r_state <= c_FIN;
                                r_done  <= 1'b1;
                            end else begin
                                r_addr  <= r_addr + c_ONE;
                                r_state <= c_ISSUE;
                            end
                        end
                    end
                    c_FIN: begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state    <= c_IDLE;
                        r_outValid <= 1'b0;
                        r_outLast  <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rd_addr   = r_addr;
    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_index = r_outIndex;
    assign out_last  = r_outLast;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_reg_dump.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_dump
// Description : Scoreboard bench for reg_dump with a registered-read register
//               file model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_dump;

    localparam int c_AW   = 5;
    localparam int c_DW   = 32;
    localparam int c_NREG = 32;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            out_ready = 1'b0;
    logic [c_AW-1:0] rd_addr;
    logic [c_DW-1:0] rd_data = '0;
    logic            out_valid;
    logic [c_DW-1:0] out_data;
    logic [c_AW-1:0] out_index;
    logic            out_last;
    logic            busy;
    logic            done;

    reg_dump #(.ADDRESS_WIDTH(c_AW), .REGISTER_SIZE(c_DW)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [c_DW-1:0] rf [c_NREG];
    always @(posedge clk) rd_data <= rf[rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [c_AW-1:0] idx;
        logic [c_DW-1:0] data;
        logic            last;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int errors = 0;
    int doneCount = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: pops an expected word on every accepted transfer.
    always @(negedge clk) begin
        if (done === 1'b1) doneCount++;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got index %0d, no word expected", out_index);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("word_index", 64'(out_index), 64'(e.idx));
                check("word_data", 64'(out_data), 64'(e.data));
                check("word_last", 64'(out_last), 64'(e.last));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushDump(input int count, input logic [c_DW-1:0] x3);
        for (int i = 0; i < count; i++) begin
            exp_t e;
            e.idx  = c_AW'(i);
            e.data = (i == 3) ? x3 : 32'h1000_0000 + i;
            e.last = (i == c_NREG - 1);
            sbq.push_back(e);
        end
    endtask

    task automatic pulseStart(output int n);
        start = 1'b1;
        tick();
        n = cyc;
        start = 1'b0;
    endtask

    task automatic waitIdx(input int idx);
        for (int i = 0; i < 300; i++) begin
            if (out_valid && out_index == c_AW'(idx)) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL wait_index: got timeout, required index %0d valid", idx);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 300; i++) begin
            if (!busy) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: got busy timeout, required busy low");
    endtask

    task automatic checkQuiet(string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int d0;
        int k;
        for (int i = 0; i < c_NREG; i++) rf[i] = 32'h1000_0000 + i;

        // Reset state
        tick(); tick();
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_index", 64'(out_index), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        checkQuiet("rst");
        reset_n = 1'b1;
        tick();

        // abort with start in IDLE: stays idle
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", 64'(busy), 64'd0);
        tick();
        checkQuiet("abort_start");

        // Full dump with ready high, timing checks
        out_ready = 1'b1;
        d0 = doneCount;
        pushDump(c_NREG, 32'h1000_0003);
        pulseStart(n);
        check("busy_rise", 64'(busy), 64'd1);
        k = 0;
        while (!out_valid && k < 10) begin tick(); k++; end
        check("first_valid_latency", 64'(cyc - n), 64'd3);
        k = 0;
        while (!done && k < 200) begin tick(); k++; end
        check("done_time", 64'(cyc - n), 64'd128);
        check("busy_in_fin", 64'(busy), 64'd1);
        tick();
        check("done_one_cycle", 64'(done), 64'd0);
        check("busy_low_after_fin", 64'(busy), 64'd0);
        check("full_done_count", 64'(doneCount - d0), 64'd1);
        check("full_sb_empty", 64'(sbq.size()), 64'd0);

        // Backpressure on index 7
        pushDump(c_NREG, 32'h1000_0003);
        pulseStart(n);
        waitIdx(7);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_index", 64'(out_index), 64'd7);
            check("bp_data", 64'(out_data), 64'h1000_0007);
        end
        out_ready = 1'b1;
        waitIdle();
        check("bp_sb_empty", 64'(sbq.size()), 64'd0);

        // Abort in SEND at index 12
        d0 = doneCount;
        pushDump(12, 32'h1000_0003);
        pulseStart(n);
        waitIdx(12);
        out_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        out_ready = 1'b1;
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        tick(); tick();
        checkQuiet("abort_after");
        check("abort_done_count", 64'(doneCount - d0), 64'd0);
        check("abort_sb_empty", 64'(sbq.size()), 64'd0);

        // Restart after abort, second start at index 5 ignored
        d0 = doneCount;
        pushDump(c_NREG, 32'h1000_0003);
        pulseStart(n);
        waitIdx(5);
        start = 1'b1;
        tick();
        start = 1'b0;
        waitIdle();
        tick(); tick();
        check("restart_done_count", 64'(doneCount - d0), 64'd1);
        check("restart_sb_empty", 64'(sbq.size()), 64'd0);

        // Reset at index 20
        pushDump(c_NREG, 32'h1000_0003);
        pulseStart(n);
        waitIdx(20);
        out_ready = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        sbq.delete();
        check("mid_rst_rd_addr", 64'(rd_addr), 64'd0);
        check("mid_rst_out_data", 64'(out_data), 64'd0);
        check("mid_rst_out_index", 64'(out_index), 64'd0);
        check("mid_rst_out_last", 64'(out_last), 64'd0);
        checkQuiet("mid_rst");
        out_ready = 1'b1;
        tick(); tick();
        checkQuiet("mid_rst_idle");

        // Fresh dump with x3 written before index 3 is read
        pushDump(c_NREG, 32'hDEAD_BEEF);
        pulseStart(n);
        rf[3] = 32'hDEAD_BEEF;
        k = 0;
        while (!out_valid && k < 10) begin tick(); k++; end
        check("post_rst_latency", 64'(cyc - n), 64'd3);
        check("post_rst_index", 64'(out_index), 64'd0);
        waitIdle();
        tick();
        check("final_sb_empty", 64'(sbq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
